// File: rtl/exe_result_queue.sv
// exe_result_queue: small FIFO capturing {result, status} pairs from the
// execution unit, presented over valid/ready, with a saturating error-result
// counter and a sticky overflow flag for pairs dropped while full.
module exe_result_queue #(
    parameter int ARG_BYTES = 4,
    parameter int DEPTH     = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rsn,
    input  logic                     i_valid,
    input  logic [ARG_BYTES-1:0]     i_result,
    input  logic [3:0]               i_status,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [ARG_BYTES-1:0]     o_result,
    output logic [3:0]               o_status,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [7:0]               o_err_cnt,
    output logic                     o_overflow,
    input  logic                     i_err_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = ARG_BYTES + 4;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    // Handshake qualification and head presentation, all derived from level.
    always_comb begin
        o_ready  = (level != FULL_LVL) && !i_rsn;
        o_valid  = (level != '0);
        push     = i_valid && o_ready;
        pop      = o_valid && i_ready;
        head     = mem[rd_ptr];
        o_result = head[EW-1:4];
        o_status = head[3:0];
        o_level  = level;
    end

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk or posedge i_rsn) begin
        if (i_rsn) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {i_result, i_status};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Error-result counter and sticky overflow; clear wins over any update.
    always_ff @(posedge i_clk or posedge i_rsn) begin
        if (i_rsn) begin
            o_err_cnt  <= '0;
            o_overflow <= 1'b0;
        end else if (i_err_clr) begin
            o_err_cnt  <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push && i_status[3] && (o_err_cnt != 8'hFF)) begin
                o_err_cnt <= o_err_cnt + 8'd1;
            end
            if (i_valid && !o_ready) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exe_result_queue.sv
// Scoreboard bench for exe_result_queue (DEPTH=4, ARG_BYTES=4).
module tb_exe_result_queue;

    logic       clk;
    logic       i_rsn;
    logic       i_valid;
    logic [3:0] i_result;
    logic [3:0] i_status;
    logic       o_ready;
    logic       o_valid;
    logic [3:0] o_result;
    logic [3:0] o_status;
    logic       i_ready;
    logic [2:0] o_level;
    logic [7:0] o_err_cnt;
    logic       o_overflow;
    logic       i_err_clr;

    int total;
    int bad;
    logic [7:0] sb [$];

    exe_result_queue #(.ARG_BYTES(4), .DEPTH(4)) dut (
        .i_clk      (clk),
        .i_rsn      (i_rsn),
        .i_valid    (i_valid),
        .i_result   (i_result),
        .i_status   (i_status),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_status   (o_status),
        .i_ready    (i_ready),
        .o_level    (o_level),
        .o_err_cnt  (o_err_cnt),
        .o_overflow (o_overflow),
        .i_err_clr  (i_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_item(input logic [3:0] r, input logic [3:0] s, input bit accepted);
        i_valid  = 1'b1;
        i_result = r;
        i_status = s;
        if (accepted) sb.push_back({r, s});
        tick();
        i_valid = 1'b0;
    endtask

    // Monitor: whenever a pop is about to happen, compare head with scoreboard.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (!i_rsn && o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got=%0h expected=none", {o_result, o_status});
                end else begin
                    exp = sb.pop_front();
                    chk("head_pair", {24'd0, o_result, o_status}, {24'd0, exp});
                end
            end
        end
    end

    initial begin
        total = 0;
        bad = 0;
        i_rsn = 1'b1;
        i_valid = 1'b0;
        i_result = '0;
        i_status = '0;
        i_ready = 1'b0;
        i_err_clr = 1'b0;

        // Reset state
        #12;
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_level", o_level, 0);
        chk("rst_result", o_result, 0);
        chk("rst_status", o_status, 0);
        chk("rst_errcnt", o_err_cnt, 0);
        chk("rst_ovf", o_overflow, 0);
        #10;
        i_rsn = 1'b0;
        #1;
        chk("post_rst_ready", o_ready, 1);
        tick();

        // 1. Single pass-through
        push_item(4'hA, 4'h1, 1);
        chk("t1_valid", o_valid, 1);
        chk("t1_result", o_result, 4'hA);
        chk("t1_status", o_status, 4'h1);
        chk("t1_level", o_level, 1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("t1_valid_after", o_valid, 0);
        chk("t1_level_after", o_level, 0);

        // 2. Fill and overflow
        for (int k = 1; k <= 4; k++) push_item(4'(k), 4'h0, 1);
        chk("t2_ready_full", o_ready, 0);
        chk("t2_level_full", o_level, 4);
        push_item(4'h5, 4'h0, 0);
        chk("t2_ovf", o_overflow, 1);
        chk("t2_level_held", o_level, 4);
        i_ready = 1'b1;
        repeat (4) tick();
        i_ready = 1'b0;
        chk("t2_level_drained", o_level, 0);
        chk("t2_sb_empty", sb.size(), 0);

        // 3. Full with simultaneous push and pop
        for (int k = 1; k <= 4; k++) push_item(4'(k), 4'h0, 1);
        i_valid = 1'b1;
        i_result = 4'h9;
        i_status = 4'h0;
        i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        i_ready = 1'b0;
        chk("t3_level", o_level, 3);
        chk("t3_ovf", o_overflow, 1);
        chk("t3_head", o_result, 4'h2);
        i_ready = 1'b1;
        repeat (3) tick();
        i_ready = 1'b0;
        chk("t3_sb_empty", sb.size(), 0);

        // Clear sticky state
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        chk("clr_ovf", o_overflow, 0);

        // 4. Streaming with pointer wrap
        i_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            push_item(4'(k), 4'h3, 1);
            chk("t4_valid", o_valid, 1);
            chk("t4_level_le1", (o_level <= 3'd1), 1);
        end
        tick();
        chk("t4_level_end", o_level, 0);
        chk("t4_sb_empty", sb.size(), 0);

        // 5. Error counting
        push_item(4'h1, 4'h8, 1);
        push_item(4'h2, 4'h8, 1);
        push_item(4'h3, 4'h8, 1);
        push_item(4'h4, 4'h0, 1);
        chk("t5_errcnt3", o_err_cnt, 3);
        i_err_clr = 1'b1;
        push_item(4'h5, 4'hF, 1);
        i_err_clr = 1'b0;
        chk("t5_clr_errcnt", o_err_cnt, 0);
        chk("t5_clr_ovf", o_overflow, 0);
        for (int k = 0; k < 260; k++) begin
            push_item(4'(k), 4'h8, 1);
            if (k == 253) chk("t5_errcnt254", o_err_cnt, 254);
        end
        chk("t5_errcnt_sat", o_err_cnt, 255);
        tick();
        i_ready = 1'b0;
        chk("t5_sb_empty", sb.size(), 0);

        // 6. Asynchronous reset mid-stream
        push_item(4'hC, 4'h4, 1);
        push_item(4'hD, 4'h5, 1);
        chk("t6_level2", o_level, 2);
        #2;
        i_rsn = 1'b1;
        #1;
        chk("t6_rst_valid", o_valid, 0);
        chk("t6_rst_level", o_level, 0);
        chk("t6_rst_result", o_result, 0);
        chk("t6_rst_errcnt", o_err_cnt, 0);
        sb.delete();
        i_rsn = 1'b0;
        tick();
        push_item(4'h7, 4'h2, 1);
        chk("t6_level1", o_level, 1);
        chk("t6_result", o_result, 4'h7);
        chk("t6_status", o_status, 4'h2);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("t6_level0", o_level, 0);
        chk("t6_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
